bus_controller: RTL and testbench
=================================

Name: bus_controller

Overview:
- Shared-bus responder for the MSI snooping caches: the far end of the messages each cache's CPU-side FSM emits (read miss, write miss, invalidate, write-back).
- Arbitrates between two cache requesters and broadcasts the winning message to the other cache's snoop FSM.
- Collects that cache's write-back/abort response and services the transaction against main memory.
- Returns fill data and a completion pulse to the requester.

Parameters:
- ADDR_W, 4, block address width.
- DATA_W, 8, block data width.
- MEM_LATENCY, 2, cycles from mem_addr presented to mem_rdata valid; must be >= 1.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  2  per-cache request; held high until req_done
- req_type  in  4  2 bits per cache: 00 read miss, 01 write miss, 10 invalidate, 11 write-back
- req_addr  in  2*ADDR_W  per-cache block address
- req_data  in  2*DATA_W  per-cache write-back data
- req_done  out  2  one-cycle completion pulse to the granted cache
- resp_data  out  DATA_W  fill data, valid while req_done is high
- snoop_valid  out  2  one-cycle broadcast strobe to the non-granted cache
- snoop_type  out  2  broadcast message type, encoded as req_type
- snoop_addr  out  ADDR_W  broadcast address
- snoop_wb  in  2  per-cache "write-back / abort memory access" reply, combinational in the snoop cycle
- snoop_data  in  2*DATA_W  per-cache dirty data accompanying snoop_wb
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write enable, one cycle per write
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- bus_state  out  3  current FSM state, for board LEDs
- grant_id  out  1  index of the cache that owns the bus

Behaviour:
- Reset (asynchronous):
  - FSM goes to IDLE and the round-robin pointer to 0.
  - All outputs go to 0.
  - A reset mid-transaction abandons it; no req_done is issued and no pending mem_we is issued.
- States and encodings: IDLE=0, SNOOP=1, MEM_READ=2, WB=3, MEM_WRITE=4, DONE=5.
- IDLE:
  - If any req_valid is set, grant: a single requester wins; if both are set, the pointer index wins.
  - On grant, latch grant_id, type, address and data; the pointer moves to the other cache.
  - A write-back request goes to MEM_WRITE; every other request type goes to SNOOP.
- SNOOP (1 cycle):
  - snoop_valid[~grant_id]=1; snoop_type and snoop_addr carry the latched request.
  - snoop_wb/snoop_data of the other cache are sampled at the end of this cycle; the requester's own snoop_wb is ignored.
  - Invalidate goes to DONE, and any snoop_wb is ignored.
  - Miss with snoop_wb=1 goes to WB (the memory read is aborted); miss with snoop_wb=0 goes to MEM_READ.
- MEM_READ:
  - mem_addr is driven and the wait counter counts MEM_LATENCY cycles.
  - mem_rdata is captured into resp_data on the last cycle, then the FSM goes to DONE.
- WB (1 cycle): mem_we=1 with the snooped data; the same data is latched into resp_data; then DONE.
- MEM_WRITE (1 cycle): mem_we=1 with the requester's data; resp_data=0; then DONE.
- DONE (1 cycle): req_done[grant_id]=1, then IDLE.
  - The requester drops req_valid on the edge that samples req_done, so it is not re-granted.
- Latency (cycle 0 = IDLE with req_valid sampled):
  - read/write miss, clean: req_done in cycle 2+MEM_LATENCY.
  - miss with snoop write-back: cycle 3.
  - invalidate: cycle 2.
  - write-back request: cycle 2.
- Request changes while busy are ignored, because request fields are latched at grant.
- snoop_valid, mem_we and req_done are never high for more than one cycle per transaction.
- The address is always passed through unmodified; no arithmetic beyond the wait counter, which is sized clog2(MEM_LATENCY+1).

Decomposition:
- Shared package:
  - Message type constants: MSG_RD_MISS, MSG_WR_MISS, MSG_INV, MSG_WB.
  - State encodings.
  - MSI state encodings already used by the cache FSMs: I=00, S=01, M=10.
- Sub-module rr_arbiter: 2-requester round-robin with a pointer update on grant.

Test Plan:
- Reset then cache0 read miss, addr 3, mem[3]=0x5A, no snoop_wb → snoop_valid=2'b10 in cycle 1; req_done=2'b01 in cycle 4; resp_data=0x5A.
- Cache1 write miss addr 6, cache0 returns snoop_wb=1 with data 0xC3 → mem_we in cycle 2 writes 0xC3 to addr 6; no memory read; req_done=2'b10 in cycle 3 with resp_data=0xC3.
- Both caches request together after reset → cache0 is served first, then cache1; with both still pending the next grant alternates back to cache0.
- Cache0 invalidate with cache1 asserting snoop_wb → snoop_wb is ignored; no mem_we; req_done=2'b01 in cycle 2.
- Cache1 write-back addr 9 data 0x77 → no snoop_valid; mem_we=1 with addr 9 / 0x77 in cycle 1; req_done=2'b10 in cycle 2.
- Reset asserted during MEM_READ → all outputs go to 0 immediately; no req_done; the next request is served with the pointer at 0.

Source files
------------

// File: rtl/bus_controller_pkg.sv
// Shared definitions for the snooping-bus responder: message types, bus FSM
// states and the MSI line states used by the cache-side FSMs.
package bus_controller_pkg;

    localparam logic [1:0] MSG_RD_MISS = 2'b00;
    localparam logic [1:0] MSG_WR_MISS = 2'b01;
    localparam logic [1:0] MSG_INV     = 2'b10;
    localparam logic [1:0] MSG_WB      = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SNOOP     = 3'd1,
        ST_MEM_READ  = 3'd2,
        ST_WB        = 3'd3,
        ST_MEM_WRITE = 3'd4,
        ST_DONE      = 3'd5
    } bus_state_e;

    typedef enum logic [1:0] {
        MSI_I = 2'b00,
        MSI_S = 2'b01,
        MSI_M = 2'b10
    } msi_state_e;

endpackage

// File: rtl/bus_controller_arbiter.sv
// Two-requester round-robin arbiter; the pointer moves to the other cache
// whenever a grant is issued.
module rr_arbiter (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic       grant_valid,
    output logic       grant_idx
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        grant_valid = grant_en & (|req);
        grant_idx   = (req == 2'b11) ? ptr_q : req[1];
        ptr_d       = ptr_q;
        if (grant_valid) begin
            ptr_d = ~grant_idx;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/bus_controller.sv
// Shared-bus responder for two MSI snooping caches: arbitrates, broadcasts the
// winning message to the other cache, then services it against main memory.
module bus_controller
    import bus_controller_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int MEM_LATENCY = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          req_valid,
    input  logic [3:0]          req_type,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_data,
    output logic [1:0]          req_done,
    output logic [DATA_W-1:0]   resp_data,
    output logic [1:0]          snoop_valid,
    output logic [1:0]          snoop_type,
    output logic [ADDR_W-1:0]   snoop_addr,
    input  logic [1:0]          snoop_wb,
    input  logic [2*DATA_W-1:0] snoop_data,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [2:0]          bus_state,
    output logic                grant_id
);

    localparam int CNT_W = $clog2(MEM_LATENCY + 1);

    bus_state_e          state_q, state_d;
    logic                grant_q, grant_d;
    logic [1:0]          type_q, type_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   resp_q, resp_d;

    logic                arb_valid;
    logic                arb_idx;
    logic [1:0]          sel_type;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;
    logic                other_wb;
    logic [DATA_W-1:0]   other_data;

    rr_arbiter u_arb (
        .clock       (clock),
        .reset       (reset),
        .req         (req_valid),
        .grant_en    (state_q == ST_IDLE),
        .grant_valid (arb_valid),
        .grant_idx   (arb_idx)
    );

    // Only the non-granted cache's snoop reply matters.
    always_comb begin
        sel_type   = arb_idx ? req_type[3:2] : req_type[1:0];
        sel_addr   = arb_idx ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
        sel_data   = arb_idx ? req_data[DATA_W +: DATA_W] : req_data[0 +: DATA_W];
        other_wb   = grant_q ? snoop_wb[0] : snoop_wb[1];
        other_data = grant_q ? snoop_data[0 +: DATA_W] : snoop_data[DATA_W +: DATA_W];
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        type_d      = type_q;
        addr_d      = addr_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        resp_d      = resp_q;
        req_done    = 2'b00;
        snoop_valid = 2'b00;
        snoop_type  = 2'b00;
        snoop_addr  = '0;
        mem_addr    = '0;
        mem_we      = 1'b0;
        mem_wdata   = '0;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_idx;
                    type_d  = sel_type;
                    addr_d  = sel_addr;
                    data_d  = sel_data;
                    state_d = (sel_type == MSG_WB) ? ST_MEM_WRITE : ST_SNOOP;
                end
            end
            ST_SNOOP: begin
                snoop_valid = grant_q ? 2'b01 : 2'b10;
                snoop_type  = type_q;
                snoop_addr  = addr_q;
                cnt_d       = '0;
                case (type_q)
                    MSG_RD_MISS, MSG_WR_MISS: begin
                        if (other_wb) begin
                            // Dirty owner supplies the block; memory read is skipped.
                            data_d  = other_data;
                            state_d = ST_WB;
                        end else begin
                            state_d = ST_MEM_READ;
                        end
                    end
                    default: state_d = ST_DONE;
                endcase
            end
            ST_MEM_READ: begin
                mem_addr = addr_q;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(MEM_LATENCY - 1)) begin
                    resp_d  = mem_rdata;
                    state_d = ST_DONE;
                end
            end
            ST_WB: begin
                mem_addr  = addr_q;
                mem_we    = 1'b1;
                mem_wdata = data_q;
                resp_d    = data_q;
                state_d   = ST_DONE;
            end
            ST_MEM_WRITE: begin
                mem_addr  = addr_q;
                mem_we    = 1'b1;
                mem_wdata = data_q;
                resp_d    = '0;
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                req_done = grant_q ? 2'b10 : 2'b01;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b0;
            type_q  <= 2'b00;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            type_q  <= type_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
        end
    end

    assign bus_state = state_q;
    assign grant_id  = grant_q;
    assign resp_data = resp_q;

endmodule

// File: tb/tb_bus_controller.sv
// Bench for bus_controller: directed and randomized transactions against a
// transaction-level model of latency, snoop traffic and memory writes.
module tb_bus_controller;
    import bus_controller_pkg::*;

    localparam int ADDR_W      = 4;
    localparam int DATA_W      = 8;
    localparam int MEM_LATENCY = 2;
    localparam int W           = ADDR_W + DATA_W;

    logic                clock;
    logic                reset;
    logic [1:0]          req_valid;
    logic [3:0]          req_type;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_data;
    logic [1:0]          req_done;
    logic [DATA_W-1:0]   resp_data;
    logic [1:0]          snoop_valid;
    logic [1:0]          snoop_type;
    logic [ADDR_W-1:0]   snoop_addr;
    logic [1:0]          snoop_wb;
    logic [2*DATA_W-1:0] snoop_data;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_we;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;
    logic [2:0]          bus_state;
    logic                grant_id;

    logic [DATA_W-1:0]   mem [16];
    logic [W-1:0]        exp_q[$];
    int                  rr_ptr;
    int                  pass_cnt;
    int                  total_cnt;

    bus_controller #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .MEM_LATENCY (MEM_LATENCY)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_type    (req_type),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_done    (req_done),
        .resp_data   (resp_data),
        .snoop_valid (snoop_valid),
        .snoop_type  (snoop_type),
        .snoop_addr  (snoop_addr),
        .snoop_wb    (snoop_wb),
        .snoop_data  (snoop_data),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .bus_state   (bus_state),
        .grant_id    (grant_id)
    );

    // Clock and watchdog
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Main memory: combinational read, write on the clock edge
    assign mem_rdata = mem[mem_addr];

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        mem[3] = 8'h5A;
        forever begin
            @(posedge clock);
            if (mem_we === 1'b1) mem[mem_addr] = mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_a"}, 32'({req_done, resp_data, snoop_valid, snoop_type, snoop_addr}), 0);
        check({tag, "_b"}, 32'({mem_addr, mem_we, mem_wdata, bus_state, grant_id}), 0);
    endtask

    // One transaction from cache r; expectations derived from message semantics.
    task automatic run_txn(input int r, input logic [1:0] t, input logic [3:0] a,
                           input logic [7:0] d, input logic [1:0] wb,
                           input logic [7:0] sd0, input logic [7:0] sd1);
        int o, cyc, done_cyc, sn_cnt, sn_cyc, we_cnt, we_cyc, rd_cnt;
        int exp_done, exp_rd, exp_we_cyc;
        bit done, exp_snoop, chk_resp;
        logic [1:0] done_val, sn_val, sn_t;
        logic [3:0] sn_a;
        logic [7:0] resp, exp_resp, sdv;
        logic gid;

        o = 1 - r;
        cyc = 0; done_cyc = 0; sn_cnt = 0; sn_cyc = 0; we_cnt = 0; we_cyc = 0; rd_cnt = 0;
        done = 1'b0; done_val = 2'b00; sn_val = 2'b00; sn_t = 2'b00; sn_a = 4'h0;
        resp = 8'h00; gid = 1'b0;
        sdv = (o == 1) ? sd1 : sd0;
        exp_snoop = (t != MSG_WB);
        chk_resp = 1'b1; exp_rd = 0; exp_we_cyc = 0; exp_resp = 8'h00;
        if (t == MSG_WB) begin
            exp_done = 2;
            exp_q.push_back({a, d});
            exp_we_cyc = 1;
        end else if (t == MSG_INV) begin
            exp_done = 2;
            chk_resp = 1'b0;
        end else if (wb[o]) begin
            exp_done = 3;
            exp_resp = sdv;
            exp_q.push_back({a, sdv});
            exp_we_cyc = 2;
        end else begin
            exp_done = 2 + MEM_LATENCY;
            exp_resp = mem[a];
            exp_rd = MEM_LATENCY;
        end
        rr_ptr = o;

        @(negedge clock);
        req_type[2*r +: 2] = t;
        req_addr[4*r +: 4] = a;
        req_data[8*r +: 8] = d;
        snoop_wb   = wb;
        snoop_data = {sd1, sd0};
        req_valid[r] = 1'b1;

        while (!done && cyc < 20) begin
            @(negedge clock);
            cyc++;
            if (cyc == 1) begin
                // Fields are latched at grant; later changes must not matter.
                req_type[2*r +: 2] = 2'($urandom);
                req_addr[4*r +: 4] = 4'($urandom);
                req_data[8*r +: 8] = 8'($urandom);
            end
            if (snoop_valid != 2'b00) begin
                sn_cnt++; sn_cyc = cyc; sn_val = snoop_valid; sn_t = snoop_type; sn_a = snoop_addr;
            end
            if (bus_state == 3'd2) rd_cnt++;
            if (mem_we === 1'b1) begin
                we_cnt++;
                we_cyc = cyc;
                check("mem_write_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("mem_write_addr_data", 32'({mem_addr, mem_wdata}), 32'(exp_q.pop_front()));
            end
            if (req_done != 2'b00) begin
                done = 1'b1; done_cyc = cyc; done_val = req_done; resp = resp_data; gid = grant_id;
                req_valid[r] = 1'b0;
            end
        end
        req_valid[r] = 1'b0;

        check("done_seen", 32'(done), 1);
        check("done_cycle", done_cyc, exp_done);
        check("done_target", 32'(done_val), 1 << r);
        check("grant_id", 32'(gid), r);
        check("snoop_count", sn_cnt, exp_snoop ? 1 : 0);
        if (exp_snoop) begin
            check("snoop_cycle", sn_cyc, 1);
            check("snoop_target", 32'(sn_val), 1 << o);
            check("snoop_type", 32'(sn_t), 32'(t));
            check("snoop_addr", 32'(sn_a), 32'(a));
        end
        check("mem_we_count", we_cnt, (exp_we_cyc != 0) ? 1 : 0);
        if (exp_we_cyc != 0) check("mem_we_cycle", we_cyc, exp_we_cyc);
        check("mem_read_cycles", rd_cnt, exp_rd);
        if (chk_resp) check("resp_data", 32'(resp), 32'(exp_resp));
        check("write_queue_drained", exp_q.size(), 0);
        exp_q.delete();
        snoop_wb = 2'b00;
    endtask

    // Both caches request invalidates together; the pointer picks the first.
    task automatic run_pair(input logic [3:0] a0, input logic [3:0] a1, input logic [1:0] wb);
        int first, cyc, got, we_cnt;
        logic [1:0] dv0, dv1;
        int dc0, dc1;

        first = rr_ptr;
        cyc = 0; got = 0; we_cnt = 0;
        dv0 = 2'b00; dv1 = 2'b00; dc0 = 0; dc1 = 0;
        @(negedge clock);
        req_type  = {MSG_INV, MSG_INV};
        req_addr  = {a1, a0};
        snoop_wb  = wb;
        req_valid = 2'b11;
        while (got < 2 && cyc < 30) begin
            @(negedge clock);
            cyc++;
            if (mem_we === 1'b1) we_cnt++;
            if (req_done != 2'b00) begin
                if (got == 0) begin dv0 = req_done; dc0 = cyc; end
                else begin dv1 = req_done; dc1 = cyc; end
                req_valid = req_valid & ~req_done;
                got++;
            end
        end
        req_valid = 2'b00;
        snoop_wb  = 2'b00;
        check("pair_done_count", got, 2);
        check("pair_first_grant", 32'(dv0), 1 << first);
        check("pair_first_cycle", dc0, 2);
        check("pair_second_grant", 32'(dv1), 1 << (1 - first));
        check("pair_second_cycle", dc1, 5);
        check("pair_no_mem_we", we_cnt, 0);
        rr_ptr = first;
    endtask

    initial begin
        int cyc, extra_done, extra_we;
        pass_cnt = 0; total_cnt = 0; rr_ptr = 0;
        reset = 1'b1;
        req_valid = 2'b00; req_type = 4'h0; req_addr = '0; req_data = '0;
        snoop_wb = 2'b00; snoop_data = '0;
        repeat (3) @(negedge clock);
        check_outputs_zero("reset_outputs");
        check("reset_state", 32'(bus_state), 0);
        reset = 1'b0;

        // Directed scenarios
        run_txn(0, MSG_RD_MISS, 4'd3, 8'h11, 2'b00, 8'h00, 8'h00);
        run_txn(1, MSG_WR_MISS, 4'd6, 8'h22, 2'b01, 8'hC3, 8'h00);
        run_pair(4'd1, 4'd2, 2'b00);
        run_pair(4'd4, 4'd5, 2'b11);
        run_txn(0, MSG_INV, 4'd7, 8'h33, 2'b10, 8'h00, 8'hEE);
        run_txn(1, MSG_WB, 4'd9, 8'h77, 2'b11, 8'hAA, 8'hBB);
        run_txn(0, MSG_RD_MISS, 4'd9, 8'h00, 2'b01, 8'h99, 8'h00);

        // Randomized traffic
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                run_pair(4'($urandom), 4'($urandom), 2'($urandom));
            end else begin
                run_txn(int'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom),
                        8'($urandom), 2'($urandom), 8'($urandom), 8'($urandom));
            end
        end

        // Reset in the middle of a memory read
        @(negedge clock);
        req_type[1:0] = MSG_RD_MISS;
        req_addr[3:0] = 4'd5;
        snoop_wb  = 2'b00;
        req_valid = 2'b01;
        cyc = 0;
        while (bus_state != 3'd2 && cyc < 10) begin
            @(negedge clock);
            cyc++;
        end
        check("reached_mem_read", 32'(bus_state), 2);
        #2 reset = 1'b1;
        #1;
        check_outputs_zero("midreset_outputs");
        req_valid = 2'b00;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        extra_done = 0; extra_we = 0;
        repeat (6) begin
            @(negedge clock);
            if (req_done != 2'b00) extra_done++;
            if (mem_we === 1'b1) extra_we++;
        end
        check("abandoned_no_done", extra_done, 0);
        check("abandoned_no_we", extra_we, 0);
        rr_ptr = 0;
        run_pair(4'd8, 4'd10, 2'b00);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
